// File: rtl/alu_pkg.sv
// Shared op codes, iterator FSM encoding and decode helpers for the
// alu_muldiv execution unit.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_AND   = 4'd0;
  localparam op_t OP_OR    = 4'd1;
  localparam op_t OP_ADD   = 4'd2;
  localparam op_t OP_XOR   = 4'd3;
  localparam op_t OP_NOR   = 4'd4;
  localparam op_t OP_SLTU  = 4'd5;
  localparam op_t OP_SUB   = 4'd6;
  localparam op_t OP_SLT   = 4'd7;
  localparam op_t OP_MULTU = 4'd8;
  localparam op_t OP_MULT  = 4'd9;
  localparam op_t OP_DIVU  = 4'd10;
  localparam op_t OP_DIV   = 4'd11;
  localparam op_t OP_MFHI  = 4'd12;
  localparam op_t OP_MFLO  = 4'd13;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Ops 8..11 are iterative; their low two bits form the iterator mode
  // {divide, signed}.
  function automatic logic is_muldiv(op_t op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per clock,
// with sign fix-up applied to the hi/lo outputs while in FIN.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q, mcand, a_raw;
  logic               is_div, neg_q, neg_r, dz;

  logic               sa, sb;
  logic [WIDTH-1:0]   ma, mb;
  logic [WIDTH:0]     step_sum, shl;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem;

  assign sa = mode[0] & a[WIDTH-1];
  assign sb = mode[0] & b[WIDTH-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  assign step_sum = q[0] ? acc + {1'b0, mcand} : acc;
  assign shl      = {acc[WIDTH-1:0], q[WIDTH-1]};
  // Extra guard bit: shl can reach 2^(WIDTH+1)-1, so borrow lives one bit up.
  assign trial    = {1'b0, shl} - {2'b00, mcand};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          state <= S_RUN;
          cnt   <= CNT_LAST;
        end
        S_RUN: begin
          if (cnt == '0) state <= S_FIN;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are always loaded on go before they are read,
  // so only the control state above needs a reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && go) begin
      acc    <= '0;
      is_div <= mode[1];
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      dz     <= mode[1] && (b == '0);
      a_raw  <= a;
      q      <= mode[1] ? ma : mb;
      mcand  <= mode[1] ? mb : ma;
    end else if (state == S_RUN) begin
      if (is_div) begin
        if (trial[WIDTH+1]) begin
          acc <= shl;
          q   <= {q[WIDTH-2:0], 1'b0};
        end else begin
          acc <= trial[WIDTH:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc <= {1'b0, step_sum[WIDTH:1]};
        q   <= {step_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  assign prod   = {acc[WIDTH-1:0], q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -q : q;
  assign rem    = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  // Divide by zero bypasses the iteration result entirely.
  assign hi = !is_div ? prod_s[2*WIDTH-1:WIDTH] : (dz ? a_raw : rem);
  assign lo = !is_div ? prod_s[WIDTH-1:0]       : (dz ? '1    : quo);

  assign busy = (state != S_IDLE);
  assign fin  = (state == S_FIN);

endmodule

// File: rtl/alu_muldiv.sv
// Registered MIPS integer execution unit: single-cycle ALU ops plus
// iterative multiply/divide into HI/LO with a start/busy/done handshake.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             ov,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             issue, go, fin;
  logic [WIDTH-1:0] iter_hi, iter_lo, sum, dif, alu_res;
  logic             alu_ov;

  assign issue = start && !busy;
  assign go    = issue && is_muldiv(op);
  assign sum   = a + b;
  assign dif   = a - b;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .mode  (op[1:0]),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .fin   (fin),
    .hi    (iter_hi),
    .lo    (iter_lo)
  );

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] == b[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      ov     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (fin) begin
        hi     <= iter_hi;
        lo     <= iter_lo;
        result <= '0;
        ov     <= 1'b0;
        done   <= 1'b1;
      end else if (issue && !go) begin
        result <= alu_res;
        ov     <= alu_ov;
        done   <= 1'b1;
      end
    end
  end

  assign z = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv: vector table for the
// single-cycle ops plus hand-written multiply/divide sequences.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, z, ov;
  logic [W-1:0] result, hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .z      (z),
    .ov     (ov),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ov;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one single-cycle op at a negedge, return at the next negedge.
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_md(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string nm, input bit inject);
    int nbusy;
    bit seen_done, moved;
    logic [W-1:0] h0, l0;
    h0 = hi; l0 = lo; nbusy = 0; seen_done = 0; moved = 0;
    op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 100 && !seen_done; k++) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (busy) nbusy++;
        if (hi !== h0 || lo !== l0) moved = 1;
        if (inject && k == 10) begin
          op = OP_MULTU; a = 1; b = 1; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check({nm, " done seen"}, W'(seen_done), 1);
    check({nm, " busy cycles"}, W'(nbusy), W + 1);
    check({nm, " hi/lo held"}, W'(moved), 0);
    check({nm, " busy low"}, W'(busy), 0);
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    check({nm, " result"}, result, 0);
    check({nm, " ov"}, W'(ov), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[2]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[5]  = '{OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    vecs[6]  = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[7]  = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0};
    vecs[8]  = '{OP_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0};
    vecs[9]  = '{OP_ADD,  32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1'b0};
    vecs[10] = '{OP_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{4'd14,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
    vecs[12] = '{OP_SUB,  32'h00000005, 32'h00000003, 32'h00000002, 1'b0};
    vecs[13] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[14] = '{4'd15,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[15] = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};

    // Reset held two cycles with start asserted.
    reset = 1'b1; start = 1'b1; op = OP_ADD; a = 32'h7FFFFFFF; b = 32'h1;
    @(negedge clk);
    @(negedge clk);
    check("reset result", result, 0);
    check("reset z", W'(z), 1);
    check("reset ov", W'(ov), 0);
    check("reset busy", W'(busy), 0);
    check("reset done", W'(done), 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle done", W'(done), 0);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d ov", i), W'(ov), W'(vecs[i].ov));
      check($sformatf("vec%0d done", i), W'(done), 1);
      check($sformatf("vec%0d z", i), W'(z), W'(vecs[i].res == '0));
    end

    // No start: done drops, result/ov hold.
    @(negedge clk);
    check("hold done", W'(done), 0);
    check("hold result", result, 32'h1);

    // Leave ov set so FIN must clear it.
    do_op(OP_ADD, 32'h7FFFFFFF, 32'h1);
    check("pre-mult ov", W'(ov), 1);
    run_md(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7", 1'b1);
    run_md(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2", 1'b0);
    run_md(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2", 1'b0);
    run_md(OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, "divu /0", 1'b0);
    run_md(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div -5/0", 1'b0);
    run_md(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1", 1'b0);
    run_md(OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, "divu max/10", 1'b0);
    run_md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max", 1'b0);

    // MFHI issued during the done cycle sees the new HI.
    do_op(OP_MFHI, 32'h0, 32'h0);
    check("mfhi result", result, 32'hFFFFFFFE);
    check("mfhi done", W'(done), 1);
    do_op(OP_MFLO, 32'h0, 32'h0);
    check("mflo result", result, 32'h1);
    check("mflo z", W'(z), 0);

    // Reset part-way through a DIVU aborts it and clears hi/lo.
    op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid-run busy", W'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", W'(busy), 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort done", W'(done), 0);
    run_md(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "multu 6*7", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
